exc_ctrl: RTL

//  Exception/interrupt controller that sequences the CP0 register block. Sits at the MEM stage:
//  - collects per-instruction exception flags and the pending hardware interrupt;
//  - picks one cause by fixed priority and drives CP0's excepttype/pc/delayslot/badaddr inputs for exactly one cycle;
//  - flushes the pipeline and supplies the redirect PC (exception vector, or EPC for ERET).

---
 rtl/exc_ctrl_if.sv | 46 ++++
 rtl/exc_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/exc_ctrl_if.sv
// Exception-controller bus: MEM-stage exception flags and CP0 state in,
// CP0 write strobe, flush and redirect out.
interface exc_ctrl_if;
  logic        valid_i;
  logic        stall_i;
  logic [31:0] pc_i;
  logic        in_delayslot_i;
  logic        adel_if_i;
  logic        ri_i;
  logic        ov_i;
  logic        syscall_i;
  logic        break_i;
  logic        adel_i;
  logic        ades_i;
  logic        eret_i;
  logic [31:0] data_addr_i;
  logic [31:0] status_i;
  logic [31:0] cause_i;
  logic [31:0] epc_i;
  logic        kill_o;
  logic [31:0] excepttype_o;
  logic [31:0] cp0_pc_o;
  logic        cp0_ds_o;
  logic [31:0] cp0_badaddr_o;
  logic        flush_o;
  logic [31:0] newpc_o;
  logic        busy_o;

  // Pipeline / CP0 side: drives the exception sources, observes the controller.
  modport master (
    output valid_i, stall_i, pc_i, in_delayslot_i,
    output adel_if_i, ri_i, ov_i, syscall_i, break_i, adel_i, ades_i, eret_i,
    output data_addr_i, status_i, cause_i, epc_i,
    input  kill_o, excepttype_o, cp0_pc_o, cp0_ds_o, cp0_badaddr_o,
    input  flush_o, newpc_o, busy_o
  );

  // Controller side.
  modport slave (
    input  valid_i, stall_i, pc_i, in_delayslot_i,
    input  adel_if_i, ri_i, ov_i, syscall_i, break_i, adel_i, ades_i, eret_i,
    input  data_addr_i, status_i, cause_i, epc_i,
    output kill_o, excepttype_o, cp0_pc_o, cp0_ds_o, cp0_badaddr_o,
    output flush_o, newpc_o, busy_o
  );
endinterface

// File: rtl/exc_ctrl.sv
// MEM-stage exception/interrupt controller: picks one cause by priority,
// issues a one-cycle CP0 write and holds the pipeline flush with redirect PC.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  exc_ctrl_if.slave   bus
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, COMMIT, HOLD} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              int_p;
  logic              any_flag;
  logic              det;
  logic [3:0]        code;
  logic [31:0]       badaddr;
  logic [31:0]       target;
  logic              unused_bits;

  assign int_p = bus.valid_i & bus.status_i[0] & ~bus.status_i[1]
               & (|(bus.cause_i[15:8] & bus.status_i[15:8]));

  assign any_flag = bus.adel_if_i | bus.ri_i | bus.ov_i | bus.syscall_i
                  | bus.break_i | bus.adel_i | bus.ades_i | bus.eret_i;

  assign det        = (state == IDLE) & bus.valid_i & ~bus.stall_i & (int_p | any_flag);
  assign bus.kill_o = det;

  assign unused_bits = ^{bus.status_i[31:16], bus.status_i[7:2],
                         bus.cause_i[31:16], bus.cause_i[7:0]};

  // Fixed-priority cause selection and bad-address source.
  always_comb begin
    code    = 4'h0;
    badaddr = 32'h0;
    if (int_p) begin
      code = 4'h1;
    end else if (bus.adel_if_i) begin
      code    = 4'h4;
      badaddr = bus.pc_i;
    end else if (bus.ri_i) begin
      code = 4'ha;
    end else if (bus.ov_i) begin
      code = 4'hc;
    end else if (bus.syscall_i) begin
      code = 4'h8;
    end else if (bus.break_i) begin
      code = 4'h9;
    end else if (bus.adel_i) begin
      code    = 4'h4;
      badaddr = bus.data_addr_i;
    end else if (bus.ades_i) begin
      code    = 4'h5;
      badaddr = bus.data_addr_i;
    end else if (bus.eret_i) begin
      code = 4'he;
    end
  end

  assign target = (code == 4'he) ? bus.epc_i : EXC_VECTOR;

  // Sequencer; output registers double as the latched exception record.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      cnt               <= '0;
      bus.excepttype_o  <= '0;
      bus.cp0_pc_o      <= '0;
      bus.cp0_ds_o      <= 1'b0;
      bus.cp0_badaddr_o <= '0;
      bus.flush_o       <= 1'b0;
      bus.newpc_o       <= '0;
      bus.busy_o        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (det) begin
            state             <= COMMIT;
            bus.excepttype_o  <= 32'(code);
            bus.cp0_pc_o      <= bus.pc_i;
            bus.cp0_ds_o      <= bus.in_delayslot_i;
            bus.cp0_badaddr_o <= badaddr;
            bus.flush_o       <= 1'b1;
            bus.newpc_o       <= target;
            bus.busy_o        <= 1'b1;
          end
        end
        COMMIT: begin
          bus.excepttype_o  <= '0;
          bus.cp0_pc_o      <= '0;
          bus.cp0_ds_o      <= 1'b0;
          bus.cp0_badaddr_o <= '0;
          cnt               <= CNT_W'(FLUSH_CYCLES - 1);
          if (FLUSH_CYCLES <= 1) begin
            state       <= IDLE;
            bus.flush_o <= 1'b0;
            bus.newpc_o <= '0;
            bus.busy_o  <= 1'b0;
          end else begin
            state <= HOLD;
          end
        end
        HOLD: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state       <= IDLE;
            bus.flush_o <= 1'b0;
            bus.newpc_o <= '0;
            bus.busy_o  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
